// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: scans NUM_DIGITS common-anode digits through one shared decoder, with dead-time and frame-boundary loads
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to auto-blank leading zero digits at capture time.
module seg_display_scheduler #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 4,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digitsIn,
    input  logic [NUM_DIGITS-1:0]   blankIn,
    input  logic                    loadReq,
    output logic                    loadAck,
    output logic [3:0]              nibbleOut,
    output logic [NUM_DIGITS-1:0]   digitEn,
    output logic                    frameDone
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    typedef enum logic {DEAD, SHOW} state_t;

    state_t                  r_state, w_state_nx;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
    logic [IDX_W-1:0]        r_idx, w_idx_nx, w_step_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow, w_shadow_nx;
    logic [NUM_DIGITS-1:0]   r_blank, w_blank_nx, w_lz_blank;
    logic                    r_first, w_first_nx;
    logic                    r_ack, w_ack_nx;
    logic                    r_frame, w_frame_nx;
    logic [3:0]              r_nib, w_nib_nx;
    logic [NUM_DIGITS-1:0]   r_en, w_en_nx;
    logic                    w_dead_end, w_show_end, w_wrap_idx, w_boundary, w_load;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic w_zero_run;

    // Blank zero digits from the top down until the first nonzero one; digit 0 always stays eligible
    always_comb begin
        w_lz_blank = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            w_zero_run    = w_zero_run && (digitsIn[4*k +: 4] == 4'd0);
            w_lz_blank[k] = w_zero_run;
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    // Next state, counters, shadow capture and registered outputs
    always_comb begin
        w_dead_end  = (r_state == DEAD) && (r_cnt == CNT_W'(DEAD_CYC - 1));
        w_show_end  = (r_state == SHOW) && (r_cnt == CNT_W'(REFRESH_DIV - 1));
        w_wrap_idx  = r_idx == IDX_W'(NUM_DIGITS - 1);
        w_step_idx  = w_wrap_idx ? '0 : r_idx + IDX_W'(1);
        w_boundary  = w_dead_end && w_wrap_idx;
        w_load      = w_boundary && loadReq;
        w_state_nx  = w_dead_end ? SHOW : w_show_end ? DEAD : r_state;
        w_cnt_nx    = (w_dead_end || w_show_end) ? '0 : r_cnt + CNT_W'(1);
        w_idx_nx    = w_dead_end ? w_step_idx : r_idx;
        w_shadow_nx = w_load ? digitsIn : r_shadow;
        w_blank_nx  = w_load ? (blankIn | w_lz_blank) : r_blank;
        w_first_nx  = r_first && !w_boundary;
        w_ack_nx    = w_load;
        w_frame_nx  = w_boundary && !r_first;
        w_nib_nx    = r_nib;
        w_en_nx     = w_show_end ? '1 : r_en;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_dead_end && IDX_W'(k) == w_step_idx) w_nib_nx = w_shadow_nx[4*k +: 4];
            if (w_dead_end) w_en_nx[k] = !(IDX_W'(k) == w_step_idx && !w_blank_nx[k]);
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= DEAD;
            r_cnt    <= '0;
            r_idx    <= IDX_W'(NUM_DIGITS - 1);
            r_shadow <= '0;
            r_blank  <= '1;
            r_first  <= 1'b1;
            r_ack    <= 1'b0;
            r_frame  <= 1'b0;
            r_nib    <= 4'd0;
            r_en     <= '1;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_idx    <= w_idx_nx;
            r_shadow <= w_shadow_nx;
            r_blank  <= w_blank_nx;
            r_first  <= w_first_nx;
            r_ack    <= w_ack_nx;
            r_frame  <= w_frame_nx;
            r_nib    <= w_nib_nx;
            r_en     <= w_en_nx;
        end
    end

    assign loadAck   = r_ack;
    assign frameDone = r_frame;
    assign nibbleOut = r_nib;
    assign digitEn   = r_en;
endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler: randomized self-checking bench against a time-arithmetic scan model
module tb_seg_display_scheduler;
    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int DC    = 2;
    localparam int SLOT  = RD + DC;
    localparam int FRAME = N * SLOT;
    localparam logic [9:0] RST_VEC = {4'h0, 4'hF, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digitsIn = '0;
    logic [3:0]  blankIn = '0;
    logic        loadReq = 1'b0;
    logic        loadAck, frameDone;
    logic [3:0]  nibbleOut, digitEn;
    logic [9:0]  got;

    int          checks = 0;
    int          errors = 0;
    int          e = 0;
    logic [15:0] m_dig = '0;
    logic [3:0]  m_blank = '1;
    logic        m_ack = 1'b0;
    logic        m_fd = 1'b0;

    seg_display_scheduler #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYC(DC), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .digitsIn(digitsIn), .blankIn(blankIn), .loadReq(loadReq),
        .loadAck(loadAck), .nibbleOut(nibbleOut), .digitEn(digitEn), .frameDone(frameDone)
    );

    always #5 clk = ~clk;
    assign got = {nibbleOut, digitEn, loadAck, frameDone};

`ifdef SEG_LEADING_ZERO_BLANK_EN
    function automatic logic [3:0] lz(input logic [15:0] d);
        lz = '0;
        for (int k = 1; k < N; k++) if ((d >> (4 * k)) == 16'd0) lz[k] = 1'b1;
    endfunction
`endif

    // Expected outputs from the number of clock edges e since reset release
    function automatic logic [9:0] exp_vec();
        int s, p, d;
        logic [3:0] nib, en;
        if (e < DC) return {4'h0, 4'hF, m_ack, m_fd};
        s   = (e - DC) / SLOT;
        p   = (e - DC) % SLOT;
        d   = s % N;
        nib = m_dig[4*d +: 4];
        en  = (p < RD && !m_blank[d]) ? ~(4'b0001 << d) : 4'hF;
        return {nib, en, m_ack, m_fd};
    endfunction

    task automatic model_reset();
        e = 0;
        m_dig = '0;
        m_blank = '1;
        m_ack = 1'b0;
        m_fd = 1'b0;
    endtask

    task automatic advance();
        logic b;
        @(posedge clk);
        e++;
        b = (e >= DC) && ((e - DC) % FRAME == 0);
        m_ack = b && loadReq;
        m_fd = b && (e > DC);
        if (m_ack) begin
            m_dig = digitsIn;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            m_blank = blankIn | lz(digitsIn);
`else
            m_blank = blankIn;
`endif
        end
        @(negedge clk);
    endtask

    task automatic reset_release();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        int fd_cnt = 0;
        loadReq = 1'b0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (got !== RST_VEC) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got, RST_VEC); end
        rst = 1'b1;
        for (int i = 0; i < 80; i++) begin
            advance();
            digitsIn = 16'($urandom);
            blankIn = 4'($urandom);
            checks++;
            if (got !== exp_vec()) begin errors++; $display("FAIL reset_idle e=%0d got=%h exp=%h", e, got, exp_vec()); end
            fd_cnt += int'(frameDone);
        end
        checks++;
        if (fd_cnt !== 3) begin errors++; $display("FAIL reset_fd_count got=%0d exp=3", fd_cnt); end
    endtask

    task automatic test_basic();
        int ack_e = -1;
        digitsIn = 16'h1234;
        blankIn = 4'h0;
        loadReq = 1'b1;
        reset_release();
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance();
            checks++;
            if (got !== exp_vec()) begin errors++; $display("FAIL basic e=%0d got=%h exp=%h", e, got, exp_vec()); end
            if (m_ack) begin
                if (ack_e < 0) ack_e = e;
                loadReq = 1'b0;
            end
        end
        checks++;
        if (ack_e !== DC) begin errors++; $display("FAIL basic_ack_latency got=%0d exp=%0d", ack_e, DC); end
    endtask

    task automatic test_tear_free();
        int n = 0;
        while (!(((e - DC) % FRAME) >= 2 * SLOT && ((e - DC) % FRAME) < 2 * SLOT + RD) && n < 60) begin
            advance();
            n++;
            checks++;
            if (got !== exp_vec()) begin errors++; $display("FAIL tear_seek e=%0d got=%h exp=%h", e, got, exp_vec()); end
        end
        digitsIn = 16'hABCD;
        loadReq = 1'b1;
        n = 0;
        do begin
            advance();
            n++;
            checks++;
            if (got !== exp_vec()) begin errors++; $display("FAIL tear_wait e=%0d got=%h exp=%h", e, got, exp_vec()); end
        end while (!loadAck && n < 40);
        checks++;
        if (!loadAck || nibbleOut !== 4'hD) begin
            errors++;
            $display("FAIL tear_ack ack=%b nib=%h exp ack=1 nib=d", loadAck, nibbleOut);
        end
        loadReq = 1'b0;
        for (int i = 0; i < FRAME + 6; i++) begin
            digitsIn = 16'($urandom);
            blankIn = 4'($urandom);
            advance();
            checks++;
            if (got !== exp_vec()) begin errors++; $display("FAIL tear_after e=%0d got=%h exp=%h", e, got, exp_vec()); end
        end
    endtask

    task automatic test_blank();
        int n = 0;
        logic lit02 = 1'b0;
        digitsIn = 16'h5678;
        blankIn = 4'b0101;
        loadReq = 1'b1;
        do begin
            advance();
            n++;
            checks++;
            if (got !== exp_vec()) begin errors++; $display("FAIL blank_wait e=%0d got=%h exp=%h", e, got, exp_vec()); end
        end while (!m_ack && n < 40);
        loadReq = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            advance();
            checks++;
            if (got !== exp_vec()) begin errors++; $display("FAIL blank_scan e=%0d got=%h exp=%h", e, got, exp_vec()); end
            if (!digitEn[0] || !digitEn[2]) lit02 = 1'b1;
        end
        checks++;
        if (lit02 !== 1'b0) begin errors++; $display("FAIL blank_dark_digits lit=%b exp=0", lit02); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int ack_e = -1;
        while (!(((e - DC) % FRAME) >= SLOT && ((e - DC) % FRAME) < SLOT + RD) && n < 60) begin
            advance();
            n++;
        end
        digitsIn = 16'h1234;
        blankIn = 4'h0;
        loadReq = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (got !== RST_VEC) begin errors++; $display("FAIL midreset_async got=%h exp=%h", got, RST_VEC); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (got !== RST_VEC) begin errors++; $display("FAIL midreset_hold got=%h exp=%h", got, RST_VEC); end
        rst = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            advance();
            checks++;
            if (got !== exp_vec()) begin errors++; $display("FAIL midreset_load e=%0d got=%h exp=%h", e, got, exp_vec()); end
            if (m_ack) begin
                if (ack_e < 0) ack_e = e;
                loadReq = 1'b0;
            end
        end
        checks++;
        if (ack_e !== DC) begin errors++; $display("FAIL midreset_ack_latency got=%0d exp=%0d", ack_e, DC); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) loadReq = ~loadReq;
            if (!loadReq || $urandom_range(0, 3) == 0) begin
                digitsIn = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
                blankIn = 4'($urandom);
            end
            advance();
            checks++;
            if (got !== exp_vec()) begin errors++; $display("FAIL random e=%0d got=%h exp=%h", e, got, exp_vec()); end
        end
        loadReq = 1'b0;
    endtask

`ifdef SEG_LEADING_ZERO_BLANK_EN
    task automatic test_lzb();
        logic [15:0] vals [2] = '{16'h0070, 16'h0000};
        logic [3:0] lit;
        for (int v = 0; v < 2; v++) begin
            int n = 0;
            digitsIn = vals[v];
            blankIn = 4'h0;
            loadReq = 1'b1;
            do begin
                advance();
                n++;
            end while (!m_ack && n < 40);
            loadReq = 1'b0;
            lit = '0;
            for (int i = 0; i < FRAME; i++) begin
                advance();
                checks++;
                if (got !== exp_vec()) begin errors++; $display("FAIL lzb_scan e=%0d got=%h exp=%h", e, got, exp_vec()); end
                lit |= ~digitEn;
            end
            checks++;
            if (lit !== ((v == 0) ? 4'b0011 : 4'b0001)) begin
                errors++;
                $display("FAIL lzb_lit val=%h got=%b exp=%b", vals[v], lit, (v == 0) ? 4'b0011 : 4'b0001);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_tear_free();
        test_blank();
        test_reset_mid();
        test_random();
`ifdef SEG_LEADING_ZERO_BLANK_EN
        test_lzb();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
